// File: rtl/sif_wa_write_buffer.sv
// sif_wa_write_buffer: first-word-fall-through write queue between the SIF
// bridge W-side strobes and a valid/ready register target. It absorbs
// target back-pressure, reports fill level and a sticky overflow flag.
// Optional build macro SIF_WB_ADDR_WINDOW_EN: only writes inside
// [WIN_BASE, WIN_BASE+WIN_SIZE) are queued; others are dropped and flagged
// on the extra sticky output wb_oow.
module sif_wa_write_buffer #(
  parameter int            DEPTH    = 8,
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter logic [AW-1:0] WIN_BASE = 16'h0000,
  parameter logic [AW-1:0] WIN_SIZE = 16'h0100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wa_wr_s,
  input  logic [AW-1:0]            wa_addr,
  input  logic [DW-1:0]            wa_data_wr,
  input  logic                     flush,
  input  logic                     ovf_clr,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [AW-1:0]            wb_addr,
  output logic [DW-1:0]            wb_data,
  output logic [$clog2(DEPTH):0]   wb_level,
  output logic                     wb_full,
  output logic                     wb_empty,
  output logic                     wb_ovf
`ifdef SIF_WB_ADDR_WINDOW_EN
  ,
  output logic                     wb_oow
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t             state;
  logic [AW+DW-1:0]   mem [DEPTH];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [PW-1:0]      rptr_nxt;
  logic               in_win;
  logic               push_ok;
  logic               pop;
  logic               ovf_set;

`ifdef SIF_WB_ADDR_WINDOW_EN
  logic               oow_set;

  // Window test is done one bit wider than the address so base+size never wraps.
  function automatic logic in_window(input logic [AW-1:0] a);
    logic [AW:0] lo;
    logic [AW:0] hi;
    lo = {1'b0, WIN_BASE};
    hi = lo + {1'b0, WIN_SIZE};
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  assign in_win = in_window(wa_addr);
`else
  logic unused_win;
  assign unused_win = ^{WIN_BASE, WIN_SIZE};
  assign in_win     = 1'b1;
`endif

  assign wb_full  = (wb_level == LW'(DEPTH));
  assign wb_empty = (wb_level == '0);
  assign rptr_nxt = rptr + PW'(1);

  // Decode this cycle's transfer events; flush overrides every transfer.
  always_comb begin
    pop     = wb_valid && wb_ready && !flush;
    push_ok = wa_wr_s && in_win && (!wb_full || pop) && !flush;
    ovf_set = wa_wr_s && in_win && wb_full && !pop && !flush;
  end

`ifdef SIF_WB_ADDR_WINDOW_EN
  assign oow_set = wa_wr_s && !in_win && !flush;
`endif

  // Entry storage; the slot at rptr always mirrors the presented head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= {wa_addr, wa_data_wr};
    end
  end

  // Drain FSM, head register, pointers, level and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_EMPTY;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      wb_level <= '0;
      wb_ovf   <= 1'b0;
`ifdef SIF_WB_ADDR_WINDOW_EN
      wb_oow   <= 1'b0;
`endif
    end else begin
      if (flush) begin
        state    <= S_EMPTY;
        wb_valid <= 1'b0;
        wptr     <= '0;
        rptr     <= '0;
        wb_level <= '0;
      end else begin
        if (push_ok) wptr <= wptr + PW'(1);
        if (pop)     rptr <= rptr_nxt;
        case ({push_ok, pop})
          2'b10:   wb_level <= wb_level + LW'(1);
          2'b01:   wb_level <= wb_level - LW'(1);
          default: wb_level <= wb_level;
        endcase
        case (state)
          S_EMPTY: begin
            if (push_ok) begin
              state    <= S_HOLD;
              wb_valid <= 1'b1;
              wb_addr  <= wa_addr;
              wb_data  <= wa_data_wr;
            end
          end
          S_HOLD: begin
            if (pop) begin
              if (wb_level == LW'(1)) begin
                if (push_ok) begin
                  wb_addr <= wa_addr;
                  wb_data <= wa_data_wr;
                end else begin
                  state    <= S_EMPTY;
                  wb_valid <= 1'b0;
                end
              end else begin
                {wb_addr, wb_data} <= mem[rptr_nxt];
              end
            end
          end
          default: begin
            state    <= S_EMPTY;
            wb_valid <= 1'b0;
          end
        endcase
      end
      if (ovf_set)      wb_ovf <= 1'b1;
      else if (ovf_clr) wb_ovf <= 1'b0;
`ifdef SIF_WB_ADDR_WINDOW_EN
      if (oow_set)      wb_oow <= 1'b1;
      else if (ovf_clr) wb_oow <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_sif_wa_write_buffer.sv
// Testbench for sif_wa_write_buffer: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a queue-based model of the buffer.
module tb_sif_wa_write_buffer;

  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wa_wr_s;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data_wr;
  logic          flush;
  logic          ovf_clr;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [LW-1:0] wb_level;
  logic          wb_full;
  logic          wb_empty;
  logic          wb_ovf;
`ifdef SIF_WB_ADDR_WINDOW_EN
  logic          wb_oow;
`endif

  sif_wa_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .wa_wr_s(wa_wr_s), .wa_addr(wa_addr),
    .wa_data_wr(wa_data_wr), .flush(flush), .ovf_clr(ovf_clr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_level(wb_level), .wb_full(wb_full),
    .wb_empty(wb_empty), .wb_ovf(wb_ovf)
`ifdef SIF_WB_ADDR_WINDOW_EN
    , .wb_oow(wb_oow)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit run_chk   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Reference model: queue of {addr,data} entries in arrival order.
  logic [AW+DW-1:0] mq[$];
  logic             m_ovf;
  logic             m_oow;

  function automatic bit m_in_win(input logic [AW-1:0] a);
`ifdef SIF_WB_ADDR_WINDOW_EN
    return (int'(a) < 32'h100);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_oow = 1'b0;
    end else begin
      bit set_o, set_w;
      set_o = 1'b0;
      set_w = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        bit do_pop, was_full;
        do_pop   = (mq.size() > 0) && wb_ready;
        was_full = (mq.size() == DEPTH);
        if (wa_wr_s && !m_in_win(wa_addr)) set_w = 1'b1;
        if (wa_wr_s && m_in_win(wa_addr) && was_full && !do_pop) set_o = 1'b1;
        if (do_pop) void'(mq.pop_front());
        if (wa_wr_s && m_in_win(wa_addr) && (!was_full || do_pop))
          mq.push_back({wa_addr, wa_data_wr});
      end
      if (set_o) m_ovf = 1'b1; else if (ovf_clr) m_ovf = 1'b0;
      if (set_w) m_oow = 1'b1; else if (ovf_clr) m_oow = 1'b0;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk("valid", wb_valid, (mq.size() != 0));
      chk("level", wb_level, mq.size());
      chk("full",  wb_full,  (mq.size() == DEPTH));
      chk("empty", wb_empty, (mq.size() == 0));
      chk("ovf",   wb_ovf,   m_ovf);
`ifdef SIF_WB_ADDR_WINDOW_EN
      chk("oow",   wb_oow,   m_oow);
`endif
      if (mq.size() != 0) begin
        chk("head_addr", wb_addr, mq[0][AW+DW-1:DW]);
        chk("head_data", wb_data, mq[0][DW-1:0]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wa_wr_s = 1'b1; wa_addr = a; wa_data_wr = d;
    step();
    wa_wr_s = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; wa_wr_s = 1'b0; wa_addr = '0; wa_data_wr = '0;
    flush = 1'b0; ovf_clr = 1'b0; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", wb_valid, 0);
    chk("rst_level", wb_level, 0);
    chk("rst_empty", wb_empty, 1);
    chk("rst_full",  wb_full,  0);
    chk("rst_ovf",   wb_ovf,   0);
    chk("rst_addr",  wb_addr,  0);
    chk("rst_data",  wb_data,  0);
    run_chk = 1'b1;

    // Single write with ready high: head visible for exactly one cycle.
    wb_ready = 1'b1;
    wr(16'h0010, 16'hA5A5);
    chk("t1_valid", wb_valid, 1);
    chk("t1_addr",  wb_addr,  16'h0010);
    chk("t1_data",  wb_data,  16'hA5A5);
    chk("t1_level", wb_level, 1);
    step();
    chk("t1_valid_after", wb_valid, 0);
    chk("t1_level_after", wb_level, 0);

    // Back-pressure: fill to DEPTH with data 1..8.
    wb_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) wr(AW'(i), DW'(i));
    chk("t2_full",  wb_full,  1);
    chk("t2_level", wb_level, 8);
    chk("t2_head",  wb_data,  1);
    chk("t2_model_level", mq.size(), 8);
    step();
    chk("t2_head_stable", wb_data, 1);

    // Overflow, then push+pop while full, then clear.
    wr(16'h0009, 16'h0009);
    chk("t3_ovf",   wb_ovf,   1);
    chk("t3_level", wb_level, 8);
    wb_ready = 1'b1;
    wr(16'h000A, 16'h000A);
    wb_ready = 1'b0;
    chk("t3_pp_level", wb_level, 8);
    chk("t3_pp_ovf",   wb_ovf,   1);
    chk("t3_pp_head",  wb_data,  2);
    chk("t3_model_tail", mq[DEPTH-1][DW-1:0], 16'h000A);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", wb_ovf, 0);
    wb_ready = 1'b1;
    n = 0;
    while (wb_level != 0 && n < 20) begin step(); n++; end
    chk("t3_drain_bounded", (n < 20), 1);
    chk("t3_drained_empty", wb_empty, 1);
    wb_ready = 1'b0;

    // Flush with a concurrent write.
    for (int i = 0; i < 3; i++) wr(AW'(16'h20 + i), DW'(16'h100 + i));
    chk("t4_level3", wb_level, 3);
    flush = 1'b1;
    wr(16'h0030, 16'h0030);
    flush = 1'b0;
    chk("t4_fl_level", wb_level, 0);
    chk("t4_fl_valid", wb_valid, 0);
    chk("t4_fl_ovf",   wb_ovf,   0);

    // Asynchronous reset mid-cycle after filling and overflowing.
    for (int i = 0; i <= DEPTH; i++) wr(AW'(16'h40 + i), DW'(16'h200 + i));
    chk("t5_pre_ovf", wb_ovf, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_valid", wb_valid, 0);
    chk("t5_rst_level", wb_level, 0);
    chk("t5_rst_empty", wb_empty, 1);
    chk("t5_rst_ovf",   wb_ovf,   0);
    chk("t5_rst_data",  wb_data,  0);
    #1 rst = 1'b0;
    step();

`ifdef SIF_WB_ADDR_WINDOW_EN
    // Window edges: 00FF is inside, 0100 is outside.
    wr(16'h00FF, 16'h1111);
    wr(16'h0100, 16'h2222);
    chk("t6_level", wb_level, 1);
    chk("t6_addr",  wb_addr,  16'h00FF);
    chk("t6_oow",   wb_oow,   1);
    chk("t6_ovf",   wb_ovf,   0);
    ovf_clr = 1'b1; flush = 1'b1;
    step();
    ovf_clr = 1'b0; flush = 1'b0;
`endif

    // Randomized traffic: low-ready phase fills the buffer, then high-ready.
    for (int c = 0; c < 3000; c++) begin
      wa_wr_s    = 1'($urandom_range(0, 1));
      wa_addr    = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 255)) : AW'($urandom);
      wa_data_wr = DW'($urandom);
      wb_ready   = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 39) == 0);
      ovf_clr    = ($urandom_range(0, 19) == 0);
      step();
    end
    wa_wr_s = 1'b0; flush = 1'b0; ovf_clr = 1'b0; wb_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
